alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 167 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU that sits between the register-file read ports and its write port.
// Add, subtract, logic and move operations take one EXEC cycle; shifts move one bit per cycle.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef NUM_REGISTERS
`define NUM_REGISTERS 8
`endif

module alu_multicycle #(
   parameter int WORD_SIZE = `WORD_SIZE,
   parameter int COUNT = `NUM_REGISTERS,
   localparam int IDX_BITS = $clog2(COUNT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           op,
   input  logic [WORD_SIZE-1:0] a,
   input  logic [WORD_SIZE-1:0] b,
   input  logic [IDX_BITS-1:0]  dst_idx,
   output logic                 busy,
   output logic                 done,
   output logic [WORD_SIZE-1:0] result,
   output logic [IDX_BITS-1:0]  wr_idx,
   output logic                 wr_en,
   output logic [3:0]           flags,
   output logic [1:0]           dbg_state
);

   localparam int CW = $clog2(WORD_SIZE + 1);
   localparam logic [WORD_SIZE:0] WS_W = (WORD_SIZE + 1)'(WORD_SIZE);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_CMP = 4'd6;
   localparam logic [3:0] OP_MOV = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;

   logic [1:0]           state;
   logic [3:0]           op_q;
   logic [WORD_SIZE-1:0] a_q;
   logic [WORD_SIZE-1:0] b_q;
   logic [IDX_BITS-1:0]  dst_q;
   logic [CW-1:0]        cnt;
   logic                 sh_c;

   logic [CW-1:0]        k_in;
   logic                 is_shift_in;
   logic                 cin;
   logic [WORD_SIZE:0]   sum;
   logic [WORD_SIZE:0]   diff;
   logic [WORD_SIZE-1:0] ex_res;
   logic                 ex_c;
   logic                 ex_v;
   logic                 ex_legal;
   logic                 ex_write;

   // Handshake: start is taken only when busy=0 (IDLE); done is a one-cycle pulse in DONE,
   // and wr_en is that same pulse qualified by the op writing back.
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign wr_en     = done && (op_q != OP_CMP) && (op_q <= OP_SHR);
   assign dbg_state = state;

   assign is_shift_in = (op == OP_SHL) || (op == OP_SHR);
   assign k_in        = ({1'b0, b} >= WS_W) ? CW'(WORD_SIZE) : CW'(b);

   always_comb begin
      cin      = (op_q == OP_ADC) ? flags[1] : 1'b0;
      sum      = {1'b0, a_q} + {1'b0, b_q} + {{WORD_SIZE{1'b0}}, cin};
      diff     = {1'b0, a_q} - {1'b0, b_q};
      ex_res   = '0;
      ex_c     = 1'b0;
      ex_v     = 1'b0;
      ex_legal = 1'b1;
      ex_write = 1'b1;
      case (op_q)
         OP_ADD, OP_ADC: begin
            ex_res = sum[WORD_SIZE-1:0];
            ex_c   = sum[WORD_SIZE];
            ex_v   = (a_q[WORD_SIZE-1] == b_q[WORD_SIZE-1]) && (sum[WORD_SIZE-1] != a_q[WORD_SIZE-1]);
         end
         OP_SUB, OP_CMP: begin
            ex_res   = diff[WORD_SIZE-1:0];
            ex_c     = diff[WORD_SIZE];
            ex_v     = (a_q[WORD_SIZE-1] != b_q[WORD_SIZE-1]) && (diff[WORD_SIZE-1] != a_q[WORD_SIZE-1]);
            ex_write = (op_q != OP_CMP);
         end
         OP_AND: ex_res = a_q & b_q;
         OP_OR:  ex_res = a_q | b_q;
         OP_XOR: ex_res = a_q ^ b_q;
         OP_MOV: ex_res = b_q;
         // Only zero-distance shifts reach EXEC; the operand passes through unchanged.
         OP_SHL, OP_SHR: ex_res = a_q;
         default: begin
            ex_legal = 1'b0;
            ex_write = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         dst_q  <= '0;
         cnt    <= '0;
         sh_c   <= 1'b0;
         result <= '0;
         wr_idx <= '0;
         flags  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q  <= op;
                  a_q   <= a;
                  b_q   <= b;
                  dst_q <= dst_idx;
                  cnt   <= k_in;
                  sh_c  <= 1'b0;
                  state <= (is_shift_in && (k_in != '0)) ? S_SHIFT : S_EXEC;
               end
            end
            S_EXEC: begin
               state  <= S_DONE;
               wr_idx <= dst_q;
               if (ex_legal) flags <= {(ex_res == '0), ex_res[WORD_SIZE-1], ex_c, ex_v};
               if (ex_write) result <= ex_res;
            end
            S_SHIFT: begin
               // One extra cycle after the last bit moves so DONE lands k+1 edges after start.
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
                  if (op_q == OP_SHL) begin
                     sh_c <= a_q[WORD_SIZE-1];
                     a_q  <= {a_q[WORD_SIZE-2:0], 1'b0};
                  end else begin
                     sh_c <= a_q[0];
                     a_q  <= {1'b0, a_q[WORD_SIZE-1:1]};
                  end
               end else begin
                  state  <= S_DONE;
                  result <= a_q;
                  wr_idx <= dst_q;
                  flags  <= {(a_q == '0), a_q[WORD_SIZE-1], sh_c, 1'b0};
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed cases followed by random operations checked
// against an arithmetic reference model of each opcode.
module tb_alu_multicycle;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] op = '0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [2:0] dst_idx = '0;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic [2:0] wr_idx;
   logic       wr_en;
   logic [3:0] flags;
   logic [1:0] dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] m_result = '0;
   logic [2:0] m_wr_idx = '0;
   logic [3:0] m_flags = '0;

   alu_multicycle #(.WORD_SIZE(8), .COUNT(8)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .dst_idx(dst_idx),
      .busy(busy), .done(done), .result(result), .wr_idx(wr_idx), .wr_en(wr_en),
      .flags(flags), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: latency, write-enable, and the new result/flags for one operation.
   task automatic model(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output bit we, output logic [7:0] r_o,
                        output logic [3:0] f_o);
      int ua, ub, sa, sb, s, ci, k;
      logic [15:0] f;
      logic [7:0] r;
      bit c, v, upd;
      ua = av; ub = bv; sa = $signed(av); sb = $signed(bv);
      lat = 1; we = 1; upd = 1; r = m_result; c = 0; v = 0;
      case (o)
         4'd0, 4'd1: begin
            ci = (o == 4'd1) ? int'(m_flags[1]) : 0;
            s = ua + ub + ci;
            r = s[7:0];
            c = (s > 255);
            v = (sa + sb + ci > 127) || (sa + sb + ci < -128);
         end
         4'd2, 4'd6: begin
            s = ua - ub;
            r = s[7:0];
            c = (ua < ub);
            v = (sa - sb > 127) || (sa - sb < -128);
            if (o == 4'd6) begin we = 0; end
         end
         4'd3: r = av & bv;
         4'd4: r = av | bv;
         4'd5: r = av ^ bv;
         4'd7: r = bv;
         4'd8, 4'd9: begin
            k = (ub > 8) ? 8 : ub;
            if (k > 0) lat = 1 + k;
            if (o == 4'd8) begin
               f = {8'h00, av} << k;
               r = f[7:0];
               c = f[8];
            end else begin
               f = {av, 8'h00} >> k;
               r = f[15:8];
               c = f[7];
            end
         end
         default: begin we = 0; upd = 0; end
      endcase
      r_o = (o == 4'd6) ? m_result : r;
      f_o = upd ? {(r == 8'h00), r[7], c, v} : m_flags;
   endtask

   // Drives one request starting now (just before a rising edge) and checks its completion.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] av,
                         input logic [7:0] bv, input logic [2:0] d, input bit extra);
      int lat, cyc;
      bit we;
      logic [7:0] er;
      logic [3:0] ef;
      model(o, av, bv, lat, we, er, ef);
      start = 1; op = o; a = av; b = bv; dst_idx = d;
      @(posedge clk); #1;
      start = 0; a = 8'($urandom); b = 8'($urandom); dst_idx = 3'($urandom);
      chk({tag, ".busy_on"}, busy, 1);
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (extra) start = (cyc == 1);
         if (extra && cyc == 1) op = 4'd0;
         @(posedge clk); #1;
         cyc++;
      end
      start = 0;
      chk({tag, ".latency"}, cyc, lat);
      chk({tag, ".wr_en"}, wr_en, we);
      chk({tag, ".result"}, result, er);
      chk({tag, ".wr_idx"}, wr_idx, d);
      chk({tag, ".flags"}, flags, ef);
      m_result = er; m_flags = ef; m_wr_idx = d;
      @(posedge clk); #1;
      chk({tag, ".done_off"}, done, 0);
      chk({tag, ".wr_en_off"}, wr_en, 0);
      chk({tag, ".busy_off"}, busy, 0);
      chk({tag, ".result_hold"}, result, m_result);
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] ro;
      logic [7:0] rb;
      #12;
      chk("reset.busy", busy, 0);
      chk("reset.done", done, 0);
      chk("reset.wr_en", wr_en, 0);
      chk("reset.result", result, 0);
      chk("reset.wr_idx", wr_idx, 0);
      chk("reset.flags", flags, 0);
      chk("reset.state", dbg_state, 0);
      @(negedge clk);
      rst = 1;

      run_op("add", 4'd0, 8'h7F, 8'h01, 3'd3, 0);
      chk("add.flags_exact", flags, 4'b0101);
      chk("add.result_exact", result, 8'h80);
      run_op("sub", 4'd2, 8'h10, 8'h20, 3'd1, 0);
      chk("sub.result_exact", result, 8'hF0);
      run_op("adc", 4'd1, 8'h01, 8'h01, 3'd2, 0);
      chk("adc.result_exact", result, 8'h03);
      run_op("cmp", 4'd6, 8'h05, 8'h05, 3'd4, 0);
      chk("cmp.flags_exact", flags, 4'b1000);
      run_op("shl", 4'd8, 8'h81, 8'd3, 3'd5, 1);
      chk("shl.result_exact", result, 8'h08);
      run_op("shr", 4'd9, 8'h01, 8'd9, 3'd6, 0);
      chk("shr.result_exact", result, 8'h00);
      run_op("illegal", 4'd12, 8'h33, 8'h44, 3'd7, 0);
      run_op("shr0", 4'd9, 8'hA5, 8'd0, 3'd0, 0);

      // Abort a long shift with an asynchronous reset between clock edges.
      start = 1; op = 4'd9; a = 8'hFF; b = 8'd9; dst_idx = 3'd2;
      @(posedge clk); #1;
      start = 0;
      repeat (3) @(posedge clk);
      #3 rst = 0;
      #1;
      chk("abort.busy", busy, 0);
      chk("abort.done", done, 0);
      chk("abort.wr_en", wr_en, 0);
      chk("abort.flags", flags, 0);
      chk("abort.result", result, 0);
      chk("abort.state", dbg_state, 0);
      m_result = '0; m_flags = '0; m_wr_idx = '0;
      repeat (2) @(posedge clk);
      #1 chk("abort.wr_en_held", wr_en, 0);
      @(negedge clk);
      rst = 1;
      run_op("post_reset", 4'd0, 8'hFF, 8'h02, 3'd5, 0);

      for (int i = 0; i < 40; i++) begin
         ro = 4'($urandom_range(0, 15));
         rb = (ro == 4'd8 || ro == 4'd9) ? 8'($urandom_range(0, 10)) : 8'($urandom);
         run_op("rand", ro, 8'($urandom), rb, 3'($urandom), ($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
